// File: rtl/pcs_pkg.sv
// Shared 64b/66b PCS definitions: sync-header encodings, block-lock state
// encoding and the header validity test.
package pcs_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  typedef enum logic [1:0] {
    LOCK_INIT = 2'd0,
    RESET_CNT = 2'd1,
    TEST_SH   = 2'd2,
    SLIP      = 2'd3
  } lock_state_t;

  function automatic logic sh_valid(input logic [1:0] sh);
    return (sh == SYNC_DATA) || (sh == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/block_lock_fsm.sv
// Rx 64b/66b block-lock controller: counts sync headers per window, asserts
// lock after a clean window and pulses a one-bit slip on bad alignment.
module block_lock_fsm
  import pcs_pkg::*;
#(
  parameter int SH_GOOD_COUNT    = 64,
  parameter int SH_INVALID_LIMIT = 16,
  parameter int SLIP_WAIT_CYCLES = 4
) (
  input  logic       i_rxc,
  input  logic       i_reset,
  input  logic [1:0] i_rx_header,
  input  logic       i_rx_valid,
  output logic       o_slip,
  output logic       o_block_lock,
  output logic [7:0] o_slip_count,
  output logic [1:0] o_lock_state
);

  localparam int                WAIT_W    = $clog2(SLIP_WAIT_CYCLES + 1);
  localparam logic [6:0]        GOOD_N    = 7'(SH_GOOD_COUNT);
  localparam logic [4:0]        INV_LIM   = 5'(SH_INVALID_LIMIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT_CYCLES - 1);

  lock_state_t       state_q, state_d;
  logic [6:0]        sh_cnt_q, sh_cnt_d;
  logic [4:0]        sh_invalid_cnt_q, sh_invalid_cnt_d;
  logic              lock_q, lock_d;
  logic              slip_q, slip_d;
  logic [7:0]        slip_count_q, slip_count_d;
  logic [WAIT_W-1:0] slip_wait_q, slip_wait_d;

  logic       hdr_bad;
  logic [6:0] sh_cnt_next;
  logic [4:0] sh_inv_next;

  always_ff @(posedge i_rxc or posedge i_reset) begin
    if (i_reset) begin
      state_q          <= LOCK_INIT;
      sh_cnt_q         <= '0;
      sh_invalid_cnt_q <= '0;
      lock_q           <= 1'b0;
      slip_q           <= 1'b0;
      slip_count_q     <= '0;
      slip_wait_q      <= '0;
    end else begin
      state_q          <= state_d;
      sh_cnt_q         <= sh_cnt_d;
      sh_invalid_cnt_q <= sh_invalid_cnt_d;
      lock_q           <= lock_d;
      slip_q           <= slip_d;
      slip_count_q     <= slip_count_d;
      slip_wait_q      <= slip_wait_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    sh_cnt_d         = sh_cnt_q;
    sh_invalid_cnt_d = sh_invalid_cnt_q;
    lock_d           = lock_q;
    slip_d           = 1'b0;
    slip_count_d     = slip_count_q;
    slip_wait_d      = slip_wait_q;
    hdr_bad          = !sh_valid(i_rx_header);
    sh_cnt_next      = sh_cnt_q + 7'd1;
    sh_inv_next      = sh_invalid_cnt_q + {4'd0, hdr_bad};

    case (state_q)
      LOCK_INIT: begin
        lock_d  = 1'b0;
        state_d = RESET_CNT;
      end
      RESET_CNT: begin
        sh_cnt_d         = '0;
        sh_invalid_cnt_d = '0;
        state_d          = TEST_SH;
      end
      TEST_SH: begin
        // A gearbox pause (i_rx_valid=0) freezes the window.
        if (i_rx_valid) begin
          if (hdr_bad && (!lock_q || sh_inv_next == INV_LIM)) begin
            state_d     = SLIP;
            lock_d      = 1'b0;
            slip_d      = 1'b1;
            slip_wait_d = WAIT_LAST;
            if (slip_count_q != 8'hFF) slip_count_d = slip_count_q + 8'd1;
          end else if (sh_cnt_next == GOOD_N) begin
            if (sh_inv_next == 5'd0) lock_d = 1'b1;
            state_d = RESET_CNT;
          end else begin
            sh_cnt_d         = sh_cnt_next;
            sh_invalid_cnt_d = sh_inv_next;
          end
        end
      end
      SLIP: begin
        // Headers are ignored while the gearbox settles on the new boundary.
        if (slip_wait_q == '0) state_d = RESET_CNT;
        else slip_wait_d = slip_wait_q - 1'b1;
      end
      default: state_d = LOCK_INIT;
    endcase
  end

  always_comb begin
    o_slip       = slip_q;
    o_block_lock = lock_q;
    o_slip_count = slip_count_q;
    o_lock_state = state_q;
  end

endmodule

// File: tb/tb_block_lock_fsm.sv
// Self-checking bench for block_lock_fsm: a reference model pushes the expected
// outputs of every driven cycle into a queue, popped after the sampling edge.
module tb_block_lock_fsm;

  localparam int W = 12;

  logic       clk;
  logic       i_reset;
  logic [1:0] i_rx_header;
  logic       i_rx_valid;
  logic       o_slip;
  logic       o_block_lock;
  logic [7:0] o_slip_count;
  logic [1:0] o_lock_state;

  logic [W-1:0] exp_q[$];
  int checks;
  int failures;

  // Reference model state (0 init, 1 reset_cnt, 2 test_sh, 3 slip)
  logic [1:0] m_state;
  int m_cnt, m_inv, m_wait, m_scnt, m_slips;
  logic m_lock, m_slip;

  block_lock_fsm dut (
    .i_rxc        (clk),
    .i_reset      (i_reset),
    .i_rx_header  (i_rx_header),
    .i_rx_valid   (i_rx_valid),
    .o_slip       (o_slip),
    .o_block_lock (o_block_lock),
    .o_slip_count (o_slip_count),
    .o_lock_state (o_lock_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 2'd0;
    m_cnt   = 0;
    m_inv   = 0;
    m_wait  = 0;
    m_scnt  = 0;
    m_lock  = 1'b0;
    m_slip  = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [1:0] h);
    bit bad;
    int n, inv;
    bad    = !(h == 2'b01 || h == 2'b10);
    m_slip = 1'b0;
    case (m_state)
      2'd0: begin
        m_lock  = 1'b0;
        m_state = 2'd1;
      end
      2'd1: begin
        m_cnt   = 0;
        m_inv   = 0;
        m_state = 2'd2;
      end
      2'd2: if (v) begin
        n   = m_cnt + 1;
        inv = m_inv + int'(bad);
        if (bad && (!m_lock || inv == 16)) begin
          m_lock  = 1'b0;
          m_slip  = 1'b1;
          if (m_scnt < 255) m_scnt++;
          m_slips++;
          m_wait  = 0;
          m_state = 2'd3;
        end else if (n == 64) begin
          if (inv == 0) m_lock = 1'b1;
          m_state = 2'd1;
        end else begin
          m_cnt = n;
          m_inv = inv;
        end
      end
      default: begin
        m_wait++;
        if (m_wait == 4) m_state = 2'd1;
      end
    endcase
  endtask

  // Drive one rx cycle, predict its outcome, then compare after the edge.
  task automatic drive(input logic v, input logic [1:0] h);
    logic [W-1:0] exp, got;
    i_rx_valid  = v;
    i_rx_header = h;
    model_step(v, h);
    exp_q.push_back({m_state, m_slip, m_lock, m_scnt[7:0]});
    @(posedge clk);
    #1;
    got = {o_lock_state, o_slip, o_block_lock, o_slip_count};
    exp = exp_q.pop_front();
    check_val("cycle", 32'(got), 32'(exp));
  endtask

  // Reset lands mid-cycle so the async drop of the outputs is observable.
  task automatic apply_reset();
    #2;
    i_reset = 1'b1;
    #1;
    check_val("rst_outs", 32'({o_slip, o_block_lock, o_slip_count}), 32'd0);
    check_val("rst_state", 32'(o_lock_state), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    i_reset = 1'b0;
  endtask

  task automatic good_run(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, (i % 3 == 0) ? 2'b10 : 2'b01);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    m_slips     = 0;
    i_reset     = 1'b1;
    i_rx_valid  = 1'b0;
    i_rx_header = 2'b00;
    model_reset();

    // 1: clean acquisition
    apply_reset();
    drive(1'b1, 2'b01);
    drive(1'b1, 2'b01);
    good_run(63);
    check_val("s1_prelock", 32'(o_block_lock), 32'd0);
    drive(1'b1, 2'b01);
    check_val("s1_lock", 32'(o_block_lock), 32'd1);
    check_val("s1_noslip", 32'(o_slip_count), 32'd0);

    // 2: unlocked invalid header slips at once, wait cycles ignored, then relock
    apply_reset();
    drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    good_run(10);
    drive(1'b1, 2'b11);
    check_val("s2_slip", 32'(o_slip), 32'd1);
    check_val("s2_count", 32'(o_slip_count), 32'd1);
    for (int i = 0; i < 4; i++) drive(1'b1, 2'b00);
    check_val("s2_slip_pulse", 32'(o_slip), 32'd0);
    drive(1'b1, 2'b11);
    good_run(64);
    check_val("s2_relock", 32'(o_block_lock), 32'd1);

    // 3: locked, 15 invalid in one window keeps lock
    drive(1'b1, 2'b01);
    for (int i = 0; i < 64; i++) drive(1'b1, (i % 4 == 1 && i < 60) ? 2'b00 : 2'b01);
    check_val("s3_lock_held", 32'(o_block_lock), 32'd1);
    check_val("s3_count", 32'(o_slip_count), 32'd1);

    // 4: 16th invalid in a window drops lock and slips on the same edge
    drive(1'b1, 2'b01);
    for (int i = 0; i < 31; i++) drive(1'b1, (i % 2 == 1) ? 2'b00 : 2'b10);
    check_val("s4_lock_pre", 32'(o_block_lock), 32'd1);
    drive(1'b1, 2'b00);
    check_val("s4_slip_lock", 32'({o_slip, o_block_lock}), 32'b10);

    // Boundary: unlocked, invalid as the 64th header still slips
    for (int i = 0; i < 5; i++) drive(1'b1, 2'b01);
    good_run(63);
    drive(1'b1, 2'b11);
    check_val("s4b_slip64", 32'({o_slip, o_block_lock}), 32'b10);
    check_val("s4b_count", 32'(o_slip_count), 32'd3);

    // 5: gearbox pauses interleaved with 64 good headers
    apply_reset();
    drive(1'b1, 2'b01);
    drive(1'b1, 2'b01);
    for (int g = 0; g < 64; g++) begin
      drive(1'b1, 2'b01);
      if (g < 63) begin
        int gap;
        gap = $urandom_range(1, 3);
        for (int k = 0; k < gap; k++) drive(1'b0, 2'($urandom_range(0, 3)));
      end
    end
    check_val("s5_lock", 32'(o_block_lock), 32'd1);

    // 6: reset while slipping and while locked
    apply_reset();
    drive(1'b1, 2'b01);
    drive(1'b1, 2'b01);
    good_run(5);
    drive(1'b1, 2'b00);
    check_val("s6_slip", 32'({o_slip, o_slip_count}), 32'h101);
    apply_reset();
    drive(1'b1, 2'b01);
    drive(1'b1, 2'b01);
    good_run(64);
    check_val("s6_relock", 32'(o_block_lock), 32'd1);
    apply_reset();

    // 7: slip counter saturation
    drive(1'b1, 2'b01);
    drive(1'b1, 2'b01);
    m_slips = 0;
    for (int c = 0; c < 4000 && m_slips < 300; c++) drive(1'b1, 2'b11);
    check_val("s7_sat", 32'(o_slip_count), 32'd255);

    // Random traffic, mostly valid headers with sparse errors and pauses
    apply_reset();
    for (int c = 0; c < 2500; c++) begin
      logic v;
      logic [1:0] h;
      v = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) h = 2'($urandom_range(0, 1) * 3);
      else h = $urandom_range(0, 1) ? 2'b01 : 2'b10;
      drive(v, h);
    end
    check_val("q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
